// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types: FSM state, the IF/ID record seen by decode, and the
// canonical NOP used to fill empty pipeline slots.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;

  // Instruction addresses are word aligned; byte-offset bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode control in, instruction-SRAM port, IF/ID outputs.
// master = fetch stage, slave = surrounding core (decode/EX/SRAM).
interface if_stage_if #(
  parameter int IM_AW = 14
);
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic             im_oe;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_dout;
  logic             id_valid_o;
  logic [31:0]      id_pc_o;
  logic [31:0]      id_inst_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, im_dout,
    output im_oe, im_addr, id_valid_o, id_pc_o, id_inst_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, im_dout,
    input  im_oe, im_addr, id_valid_o, id_pc_o, id_inst_o
  );
endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer: parks the SRAM word that returns while decode is
// stalled, so the read is never repeated and never lost.
module if_skid_buf #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] cap_pc,
  input  logic [31:0] cap_inst,
  output logic        full,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_inst
);

  logic        full_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (clear || drain) begin
      full_q <= 1'b0;
    end else if (capture) begin
      full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= 32'h0;
      inst_q <= NOP_INST;
    end else if (capture && !clear) begin
      pc_q   <= cap_pc;
      inst_q <= cap_inst;
    end
  end

  assign full     = full_q;
  assign buf_pc   = pc_q;
  assign buf_inst = inst_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch: PC register, synchronous I-SRAM read, skid buffer
// for decode stalls, and the IF/ID register. Redirect beats stall beats advance.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 14,
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc;
  logic        fetch;
  if_id_t      ifid_q, ifid_d;

  logic        buf_capture, buf_drain, buf_clear, buf_full;
  logic [31:0] buf_pc, buf_inst;

  if_skid_buf #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (buf_capture),
    .drain    (buf_drain),
    .clear    (buf_clear),
    .cap_pc   (pc_q),
    .cap_inst (bus.im_dout),
    .full     (buf_full),
    .buf_pc   (buf_pc),
    .buf_inst (buf_inst)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch       = 1'b0;
    fetch_pc    = pc_q;
    ifid_d      = ifid_q;
    buf_capture = 1'b0;
    buf_drain   = 1'b0;
    buf_clear   = 1'b0;

    if (bus.redirect_i) begin
      // Whatever is in flight or parked belongs to the wrong path.
      fetch       = 1'b1;
      fetch_pc    = align_pc(bus.redirect_pc_i);
      pc_d        = fetch_pc;
      ifid_d      = '{valid: 1'b0, pc: ifid_q.pc, inst: NOP_INST};
      buf_clear   = 1'b1;
      state_d     = STREAM;
    end else if (bus.stall_i) begin
      // The word read last cycle arrives now whether or not decode can take it.
      if (state_q == STREAM) begin
        buf_capture = 1'b1;
        state_d     = HOLD;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          fetch   = 1'b1;
          ifid_d  = '{valid: 1'b0, pc: ifid_q.pc, inst: NOP_INST};
          state_d = STREAM;
        end
        STREAM: begin
          ifid_d   = '{valid: 1'b1, pc: pc_q, inst: bus.im_dout};
          fetch    = 1'b1;
          fetch_pc = pc_q + 32'd4;
          pc_d     = fetch_pc;
        end
        HOLD: begin
          ifid_d    = '{valid: buf_full, pc: buf_pc,
                        inst: buf_full ? buf_inst : NOP_INST};
          fetch     = 1'b1;
          fetch_pc  = buf_pc + 32'd4;
          pc_d      = fetch_pc;
          buf_drain = 1'b1;
          state_d   = STREAM;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, pc: 32'h0, inst: NOP_INST};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  // Read enable is masked by reset so the SRAM stays quiet while held in reset.
  assign bus.im_oe      = fetch & rst_n;
  assign bus.im_addr    = fetch_pc[IM_AW+1:2];
  assign bus.id_valid_o = ifid_q.valid;
  assign bus.id_pc_o    = ifid_q.pc;
  assign bus.id_inst_o  = ifid_q.inst;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, async-reset sequence, and a
// randomized run against a stream-level reference model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam int          IM_AW = 14;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst_n;

  if_stage_if #(.IM_AW(IM_AW)) bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IM_AW    (IM_AW),
    .NOP_INST (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: word k holds 0x1000_0000 + k.
  always @(posedge clk) begin
    if (bus.im_oe) bus.im_dout <= 32'h1000_0000 + {{(32-IM_AW){1'b0}}, bus.im_addr};
  end

  int n_vec;
  int n_fail;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        chk_addr;
    logic [13:0] exp_addr;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rpc,
                              logic ev, logic [31:0] epc, logic ca, logic [13:0] ea);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = d; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.chk_addr = ca; v.exp_addr = ea;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + {18'd0, pc[15:2]};
  endfunction

  task automatic check_out(input string name, input logic ev, input logic [31:0] epc,
                           input logic pc_chk);
    logic [31:0] ei;
    ei = ev ? mem_word(epc) : NOP;
    n_vec++;
    if (bus.id_valid_o !== ev || bus.id_inst_o !== ei || (pc_chk && bus.id_pc_o !== epc)) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b pc=%h inst=%h, want valid=%0b pc=%h inst=%h",
               name, bus.id_valid_o, bus.id_pc_o, bus.id_inst_o, ev, epc, ei);
    end
  endtask

  task automatic check_fetch(input string name, input logic eoe, input logic [13:0] ea,
                             input logic addr_chk);
    n_vec++;
    if (bus.im_oe !== eoe || (addr_chk && bus.im_addr !== ea)) begin
      n_fail++;
      $display("FAIL %s: got im_oe=%0b im_addr=%h, want im_oe=%0b im_addr=%h",
               name, bus.im_oe, bus.im_addr, eoe, ea);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;

    //            rst stl rdr rpc            ev  exp_pc         ca  addr
    vecs[0]  = mk(0,  0,  0,  32'h0,         0,  32'h0,         0,  14'h0);
    vecs[1]  = mk(1,  0,  0,  32'h0,         0,  32'h0,         0,  14'h0);
    vecs[2]  = mk(1,  0,  0,  32'h0,         1,  32'h0,         0,  14'h0);
    vecs[3]  = mk(1,  0,  0,  32'h0,         1,  32'h4,         0,  14'h0);
    vecs[4]  = mk(1,  0,  0,  32'h0,         1,  32'h8,         0,  14'h0);
    vecs[5]  = mk(1,  0,  0,  32'h0,         1,  32'hC,         0,  14'h0);
    vecs[6]  = mk(1,  1,  0,  32'h0,         1,  32'hC,         0,  14'h0);
    vecs[7]  = mk(1,  1,  0,  32'h0,         1,  32'hC,         0,  14'h0);
    vecs[8]  = mk(1,  1,  0,  32'h0,         1,  32'hC,         0,  14'h0);
    vecs[9]  = mk(1,  0,  0,  32'h0,         1,  32'h10,        0,  14'h0);
    vecs[10] = mk(1,  0,  0,  32'h0,         1,  32'h14,        0,  14'h0);
    vecs[11] = mk(1,  0,  0,  32'h0,         1,  32'h18,        0,  14'h0);
    vecs[12] = mk(0,  0,  0,  32'h0,         0,  32'h0,         0,  14'h0);
    vecs[13] = mk(1,  0,  0,  32'h0,         0,  32'h0,         0,  14'h0);
    vecs[14] = mk(1,  0,  0,  32'h0,         1,  32'h0,         0,  14'h0);
    vecs[15] = mk(1,  0,  0,  32'h0,         1,  32'h4,         0,  14'h0);
    vecs[16] = mk(1,  0,  0,  32'h0,         1,  32'h8,         0,  14'h0);
    vecs[17] = mk(1,  0,  1,  32'h200,       0,  32'h0,         1,  14'h80);
    vecs[18] = mk(1,  0,  0,  32'h0,         1,  32'h200,       0,  14'h0);
    vecs[19] = mk(1,  0,  0,  32'h0,         1,  32'h204,       0,  14'h0);
    vecs[20] = mk(1,  1,  0,  32'h0,         1,  32'h204,       0,  14'h0);
    vecs[21] = mk(1,  1,  1,  32'h300,       0,  32'h0,         1,  14'hC0);
    vecs[22] = mk(1,  1,  0,  32'h0,         0,  32'h0,         0,  14'h0);
    vecs[23] = mk(1,  0,  0,  32'h0,         1,  32'h300,       0,  14'h0);
    vecs[24] = mk(1,  0,  0,  32'h0,         1,  32'h304,       0,  14'h0);
    vecs[25] = mk(1,  0,  1,  32'h203,       0,  32'h0,         1,  14'h80);
    vecs[26] = mk(1,  0,  0,  32'h0,         1,  32'h200,       0,  14'h0);
    vecs[27] = mk(1,  0,  1,  32'hFFFF_FFFC, 0,  32'h0,         1,  14'h3FFF);
    vecs[28] = mk(1,  0,  0,  32'h0,         1,  32'hFFFF_FFFC, 0,  14'h0);
    vecs[29] = mk(1,  0,  0,  32'h0,         1,  32'h0,         0,  14'h0);

    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 1'b0, 32'h0, 1'b1);
    check_fetch("reset_im_oe", 1'b0, 14'h0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rst_n             = vecs[i].rst_n;
      bus.stall_i       = vecs[i].stall;
      bus.redirect_i    = vecs[i].redir;
      bus.redirect_pc_i = vecs[i].rpc;
      if (vecs[i].chk_addr) begin
        #1;
        check_fetch($sformatf("vec%0d_fetch", i), 1'b1, vecs[i].exp_addr, 1'b1);
      end
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_valid | ~vecs[i].rst_n);
    end

    // Reset asserted mid-stream must clear outputs before any clock edge.
    bus.stall_i    = 1'b0;
    bus.redirect_i = 1'b0;
    @(posedge clk);
    #1;
    check_out("wrap_stream", 1'b1, 32'h4, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 32'h0, 1'b1);
    check_fetch("async_reset_im_oe", 1'b0, 14'h0, 1'b0);

    // Randomized run against a stream-level model.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    begin
      int          need;
      logic [31:0] next_pc;
      logic        m_valid;
      logic [31:0] m_pc;
      logic        s, d;
      logic [31:0] tgt;
      need    = 2;
      next_pc = 32'h0;
      m_valid = 1'b0;
      m_pc    = 32'h0;
      for (int c = 0; c < 3000; c++) begin
        s = ($urandom_range(0, 3) == 0);
        d = ($urandom_range(0, 15) == 0);
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        bus.stall_i       = s;
        bus.redirect_i    = d;
        bus.redirect_pc_i = tgt;
        if (d) begin
          m_valid = 1'b0;
          next_pc = {tgt[31:2], 2'b00};
          need    = 1;
        end else if (!s) begin
          if (need > 1) begin
            need--;
            m_valid = 1'b0;
          end else begin
            need    = 0;
            m_valid = 1'b1;
            m_pc    = next_pc;
            next_pc = next_pc + 32'd4;
          end
        end
        @(posedge clk);
        #1;
        check_out($sformatf("rand%0d", c), m_valid, m_pc, m_valid);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I core: PC register, synchronous instruction-SRAM interface, one-entry skid buffer, and the IF/ID pipeline register.
- Its IF/ID outputs feed the decode stage: the control decoder and immediate generator read id_inst_o directly.
- Handles decode stalls and EX-stage redirects (taken branch / JAL / JALR) without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- IM_AW, 14, instruction-SRAM word-address width.
- NOP_INST, 32'h0000_0013, value driven on id_inst_o when id_valid_o=0 (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode hazard stall: hold IF/ID contents and stop advancing PC.
- redirect_i  in  1  EX redirect: flush and fetch from redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 00).
- im_oe  out  1  SRAM read enable.
- im_addr  out  IM_AW  SRAM word address = fetch_pc[IM_AW+1:2].
- im_dout  in  32  SRAM read data, valid the cycle after im_oe/im_addr.
- id_valid_o  out  1  IF/ID holds a real instruction.
- id_pc_o  out  32  PC of the IF/ID instruction.
- id_inst_o  out  32  IF/ID instruction; NOP_INST when id_valid_o=0.

Behaviour:
- State: pc_q (address of in-flight read), buf_pc/buf_inst, IF/ID regs, and a 3-state FSM:
  - IDLE: no read in flight, buffer empty.
  - STREAM: read of pc_q in flight.
  - HOLD: buffer full, nothing in flight.
- Reset (async, rst_n=0):
  - FSM=IDLE, pc_q=RESET_PC, buffer empty.
  - id_valid_o=0, id_pc_o=0, id_inst_o=NOP_INST, im_oe=0.
- Priority each cycle: redirect_i > stall_i > normal advance.
- redirect_i=1 (any state, also during stall):
  - Issue im_oe=1, im_addr=redirect_pc_i[IM_AW+1:2]; pc_q<={redirect_pc_i[31:2],2'b00}.
  - Clear id_valid_o; discard buffer and in-flight data; FSM->STREAM.
- stall_i=1, no redirect:
  - IF/ID holds; im_oe=0.
  - In STREAM: capture im_dout into buf_inst, pc_q into buf_pc; FSM->HOLD.
  - In IDLE or HOLD: no change.
- Normal advance (stall_i=0, redirect_i=0):
  - IDLE: issue fetch of pc_q; id_valid<=0; ->STREAM.
  - STREAM: IF/ID<={pc_q, im_dout}, valid=1; issue pc_q+4; pc_q<=pc_q+4; stay STREAM.
  - HOLD: IF/ID<={buf_pc, buf_inst}, valid=1; issue buf_pc+4; pc_q<=buf_pc+4; ->STREAM.
- Latency: reset release to first id_valid_o=1 is 2 cycles; steady-state throughput is 1 instruction/cycle.
- Redirect penalty: target instruction reaches IF/ID 2 edges after the redirect cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); im_addr truncates to IM_AW bits.
- Invariants:
  - An instruction is never presented twice, and none is skipped.
  - A flushed instruction never sets id_valid_o.
  - id_inst_o = NOP_INST whenever id_valid_o=0.
  - Reset asserted mid-stream returns to the reset state immediately, no extra edge needed.

Decomposition:
- Shared core package holds:
  - if_state_e enum (IDLE/STREAM/HOLD).
  - NOP_INST constant.
  - An if_id_t struct {valid, pc, inst}, also consumed by the decode stage.
- One natural sub-module, if_skid_buf: 1-entry buffer with capture/release/clear.
- PC-next mux and FSM stay in if_stage.

Test Plan:
- Reset then free-run, SRAM word k = 32'h1000_0000+k:
  - id_valid_o rises 2 cycles after rst_n release.
  - id_pc_o = 0,4,8,... on consecutive cycles with matching id_inst_o.
- Stall for 3 cycles while streaming at pc 0x10:
  - IF/ID holds pc 0x0C for all 3 cycles.
  - After release: 0x10, then 0x14 on consecutive cycles; no duplicate, no gap.
- redirect_i with target 0x200 while IF/ID holds 0x08:
  - Next cycle id_valid_o=0 and id_inst_o=0x00000013.
  - Following cycle id_pc_o=0x200.
- redirect_i and stall_i asserted together while in HOLD:
  - Redirect wins and the buffer is discarded.
  - id_pc_o=target 2 cycles later once stall drops.
- redirect_pc_i=0x203: im_addr=0x80 and id_pc_o=0x200 (low bits cleared).
- Redirect to 0xFFFF_FFFC:
  - id_pc_o sequence 0xFFFF_FFFC, 0x0000_0000.
  - Then assert rst_n=0 mid-stream: outputs go to reset values asynchronously, without waiting for a clock edge.
